// File: rtl/oled_ssd1306_sink_pkg.sv
// SSD1306 opcode set, decoder state encoding and opcode-to-argument-count lookup
// shared by the OLED link sink and anything else speaking the same command set.
package oled_ssd1306_sink_pkg;

    localparam logic [7:0] CMD_MEMMODE       = 8'h20;
    localparam logic [7:0] CMD_COLADDR       = 8'h21;
    localparam logic [7:0] CMD_PAGEADDR      = 8'h22;
    localparam logic [7:0] CMD_SETCONTRAST   = 8'h81;
    localparam logic [7:0] CMD_CHARGEPUMP    = 8'h8D;
    localparam logic [7:0] CMD_SETMULTIPLEX  = 8'hA8;
    localparam logic [7:0] CMD_DISPLAYOFF    = 8'hAE;
    localparam logic [7:0] CMD_DISPLAYON     = 8'hAF;
    localparam logic [7:0] CMD_SETDISPOFFSET = 8'hD3;
    localparam logic [7:0] CMD_SETCLKDIV     = 8'hD5;
    localparam logic [7:0] CMD_SETPRECHARGE  = 8'hD9;
    localparam logic [7:0] CMD_SETCOMPINS    = 8'hDA;
    localparam logic [7:0] CMD_SETVCOMDESEL  = 8'hDB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG_SKIP,
        ST_COL_START,
        ST_COL_END,
        ST_PAGE_START,
        ST_PAGE_END
    } dec_state_e;

    function automatic logic [1:0] ssd1306_arg_count(input logic [7:0] op);
        case (op)
            CMD_COLADDR, CMD_PAGEADDR: return 2'd2;
            CMD_MEMMODE, CMD_SETCONTRAST, CMD_CHARGEPUMP, CMD_SETMULTIPLEX,
            CMD_SETDISPOFFSET, CMD_SETCLKDIV, CMD_SETPRECHARGE,
            CMD_SETCOMPINS, CMD_SETVCOMDESEL: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/oled_ssd1306_sink_spi_rx.sv
// SPI byte deserialiser (MSB first, SPI clock == clk): strobe one cycle after the 8th bit.
// No backpressure: a byte every 8 clocks while cs_n stays low; cs_n high drops partial bytes.
module oled_spi_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       cs_n,
    input  logic       dc,
    output logic       byte_vld,
    output logic [7:0] byte_dat,
    output logic       byte_dc
);

    logic [2:0] cnt_q,   cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       vld_q,   vld_d;
    logic [7:0] dat_q,   dat_d;
    logic       dc_q,    dc_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        dat_d   = dat_q;
        dc_d    = dc_q;
        if (cs_n) begin
            cnt_d   = 3'd0;
            shift_d = 7'd0;
        end else begin
            shift_d = {shift_q[5:0], din};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                vld_d = 1'b1;
                dat_d = {shift_q, din};
                dc_d  = dc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 3'd0;
            shift_q <= 7'd0;
            vld_q   <= 1'b0;
            dat_q   <= 8'd0;
            dc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            dc_q    <= dc_d;
        end
    end

    assign byte_vld = vld_q;
    assign byte_dat = dat_q;
    assign byte_dc  = dc_q;

endmodule

// File: rtl/oled_ssd1306_sink.sv
// SSD1306 link sink: decodes commands and writes data bytes into a page-organised framebuffer.
// Write/pointer update in the byte_valid cycle; rd_data 1-cycle latency; no backpressure.
module oled_ssd1306_sink
    import oled_ssd1306_sink_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int PAGES = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pin_din,
    input  logic                              pin_clk,
    input  logic                              pin_cs,
    input  logic                              pin_dc,
    input  logic                              pin_res,
    input  logic [$clog2(WIDTH*PAGES)-1:0]    rd_addr,
    output logic [7:0]                        rd_data,
    output logic                              byte_valid,
    output logic [7:0]                        byte_out,
    output logic                              byte_is_data,
    output logic                              display_on,
    output logic                              frame_done,
    output logic                              cmd_error
);

    localparam int COL_W  = $clog2(WIDTH);
    localparam int PAGE_W = $clog2(PAGES);
    localparam int DEPTH  = WIDTH * PAGES;

    logic rst_i;
    logic unused_pin_clk;
    assign rst_i          = rst | ~pin_res;
    assign unused_pin_clk = pin_clk;

    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       rx_dc;

    oled_spi_rx u_spi_rx (
        .clk      (clk),
        .rst      (rst_i),
        .din      (pin_din),
        .cs_n     (pin_cs),
        .dc       (pin_dc),
        .byte_vld (rx_vld),
        .byte_dat (rx_dat),
        .byte_dc  (rx_dc)
    );

    dec_state_e         state_q, state_d;
    logic [COL_W-1:0]   arg_q, arg_d;
    logic [COL_W-1:0]   col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PAGE_W-1:0]  page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic               display_on_q, display_on_d;
    logic               cmd_error_q, cmd_error_d;
    logic               fb_we;

    always_comb begin
        state_d      = state_q;
        arg_d        = arg_q;
        col_d        = col_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_d       = page_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        display_on_d = display_on_q;
        cmd_error_d  = cmd_error_q;
        fb_we        = 1'b0;
        frame_done   = 1'b0;
        if (rx_vld && !rst_i) begin
            if (rx_dc) begin
                // Data while an argument is outstanding is dropped, decoder state kept.
                if (state_q != ST_IDLE) begin
                    cmd_error_d = 1'b1;
                end else begin
                    fb_we = 1'b1;
                    if (col_q == col_end_q) begin
                        col_d = col_start_q;
                        if (page_q == page_end_q) begin
                            page_d     = page_start_q;
                            frame_done = 1'b1;
                        end else begin
                            page_d = page_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        case (ssd1306_arg_count(rx_dat))
                            2'd2:    state_d = (rx_dat == CMD_COLADDR) ? ST_COL_START : ST_PAGE_START;
                            2'd1:    state_d = ST_ARG_SKIP;
                            default: state_d = ST_IDLE;
                        endcase
                        if (rx_dat == CMD_DISPLAYON)  display_on_d = 1'b1;
                        if (rx_dat == CMD_DISPLAYOFF) display_on_d = 1'b0;
                    end
                    ST_COL_START: begin
                        arg_d   = rx_dat[COL_W-1:0];
                        state_d = ST_COL_END;
                    end
                    ST_COL_END: begin
                        col_start_d = arg_q;
                        col_end_d   = rx_dat[COL_W-1:0];
                        col_d       = arg_q;
                        state_d     = ST_IDLE;
                    end
                    ST_PAGE_START: begin
                        arg_d   = rx_dat[COL_W-1:0];
                        state_d = ST_PAGE_END;
                    end
                    ST_PAGE_END: begin
                        page_start_d = arg_q[PAGE_W-1:0];
                        page_end_d   = rx_dat[PAGE_W-1:0];
                        page_d       = arg_q[PAGE_W-1:0];
                        state_d      = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            arg_q        <= '0;
            col_q        <= '0;
            col_start_q  <= '0;
            col_end_q    <= COL_W'(WIDTH - 1);
            page_q       <= '0;
            page_start_q <= '0;
            page_end_q   <= PAGE_W'(PAGES - 1);
            display_on_q <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg_q        <= arg_d;
            col_q        <= col_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_q       <= page_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            display_on_q <= display_on_d;
            cmd_error_q  <= cmd_error_d;
        end
    end

    // Framebuffer is deliberately left out of reset so it maps onto block RAM.
    logic [7:0] fb_mem [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (fb_we) fb_mem[{page_q, col_q}] <= rx_dat;
        rd_data_q <= fb_mem[rd_addr];
    end

    assign rd_data      = rd_data_q;
    assign byte_valid   = rx_vld;
    assign byte_out     = rx_dat;
    assign byte_is_data = rx_dc;
    assign display_on   = display_on_q;
    assign cmd_error    = cmd_error_q;

endmodule
